// File: rtl/rom_arbiter_pkg.sv
// Shared widths, FSM states and port IDs for rom_arbiter.
// Also provides the ROM_BOUND_BIT default.
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

package rom_arbiter_pkg;
  localparam int ADDR_W = `API_ADDR_WIDTH;
  localparam int DATA_W = `API_DATA_WIDTH;
  localparam int ROM_BOUND_BIT_DEF = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;
endpackage

// File: rtl/rom_arbiter_grant.sv
// Two-way combinational grant for rom_arbiter.
// ROM_ARB_RR_EN: round-robin on contention, else fetch wins.
module rom_arb_grant
  import rom_arbiter_pkg::*;
(
  input  logic  if_valid_i,
  input  logic  ls_valid_i,
  input  port_e last_i,
  output logic  gnt_o,
  output port_e gnt_id_o
);

  port_e contend_id;

`ifdef ROM_ARB_RR_EN
  assign contend_id = (last_i == PORT_IF) ? PORT_LS : PORT_IF;
`else
  logic unused_last;
  assign unused_last = last_i;
  assign contend_id  = PORT_IF;
`endif

  assign gnt_o = if_valid_i | ls_valid_i;

  always_comb begin
    gnt_id_o = PORT_IF;
    unique case (1'b1)
      (if_valid_i && ls_valid_i):  gnt_id_o = contend_id;
      (!if_valid_i && ls_valid_i): gnt_id_o = PORT_LS;
      default:                     gnt_id_o = PORT_IF;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates fetch and load ports onto a single ROM read port.
// Build macro ROM_ARB_RR_EN selects round-robin contention.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ROM_BOUND_BIT = ROM_BOUND_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [DATA_W-1:0] if_resp_data,
  output logic              if_resp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_resp_valid,
  input  logic              ls_resp_ready,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic              ls_resp_err,
  output logic              rom_en_n,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              busy_o
);

  state_e            state_q, state_d;
  port_e             gid_q, gid_d;
  port_e             last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              gnt;
  port_e             gnt_id;
  logic [ADDR_W-1:0] req_addr;
  logic              oor;
  logic              resp_hs;

  rom_arb_grant u_grant (
    .if_valid_i (if_req_valid),
    .ls_valid_i (ls_req_valid),
    .last_i     (last_q),
    .gnt_o      (gnt),
    .gnt_id_o   (gnt_id)
  );

  assign req_addr = (gnt_id == PORT_LS) ? ls_req_addr : if_req_addr;
  assign oor      = |req_addr[ADDR_W-1:ROM_BOUND_BIT];
  assign resp_hs  = (gid_q == PORT_LS) ? ls_resp_ready : if_resp_ready;

  always_comb begin
    state_d      = state_q;
    gid_d        = gid_q;
    last_d       = last_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt) begin
          if_req_ready = (gnt_id == PORT_IF);
          ls_req_ready = (gnt_id == PORT_LS);
          gid_d        = gnt_id;
          last_d       = gnt_id;
          addr_d       = req_addr;
          if (oor) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        data_d  = rom_data_i;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gid_q   <= PORT_IF;
      last_q  <= PORT_LS;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign if_resp_valid = (state_q == ST_RESP) && (gid_q == PORT_IF);
  assign ls_resp_valid = (state_q == ST_RESP) && (gid_q == PORT_LS);
  assign if_resp_data  = data_q;
  assign ls_resp_data  = data_q;
  assign if_resp_err   = err_q;
  assign ls_resp_err   = err_q;
  assign rom_en_n      = (state_q != ST_ISSUE);
  assign rom_addr_o    = addr_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule
